// File: rtl/cache_bus_arb.sv
// -----------------------------------------------------------------------------
// cache_bus_arb
//
// Two-master Avalon-MM burst arbiter. It shares one external memory bus
// between the instruction-cache (s0) and data-cache (s1) refill/writeback
// masters. One master is granted at a time, and the grant is held until that
// master's whole burst has completed.
//
// Arbitration policy:
//   default                      : round-robin. When both masters request,
//                                  the master that was not granted last wins.
//   CACHE_BUS_ARB_FIXED_PRIO_EN  : fixed priority. Master 1 (dcache) always
//                                  wins when both masters request.
//
// Ports:
//   clk, rest                  clock; asynchronous active-low reset
//   s0_* / s1_*                slave-side ports facing the icache / dcache
//                              master:
//                                address, byteEnable, read, write, writeData,
//                                beginBurstTransfer, burstCount   (inputs)
//                                waitRequest, readData, readDataValid (outputs)
//   m0_*                       master-side port facing the system bus
//   bus_idle                   high in IDLE while neither master is requesting
//
// Timing notes:
//   - A grant costs one IDLE cycle, and there is always at least one IDLE
//     cycle between two bursts.
//   - A burstCount of 0 is treated as a single beat.
// -----------------------------------------------------------------------------
module cache_bus_arb #(
    parameter int BURST_COUNT_WIDTH = 8,
    parameter int ADDR_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rest,

    input  logic [ADDR_WIDTH-1:0]        s0_address,
    input  logic [3:0]                   s0_byteEnable,
    input  logic                         s0_read,
    input  logic                         s0_write,
    input  logic [31:0]                  s0_writeData,
    input  logic                         s0_beginBurstTransfer,
    input  logic [BURST_COUNT_WIDTH-1:0] s0_burstCount,
    output logic                         s0_waitRequest,
    output logic [31:0]                  s0_readData,
    output logic                         s0_readDataValid,

    input  logic [ADDR_WIDTH-1:0]        s1_address,
    input  logic [3:0]                   s1_byteEnable,
    input  logic                         s1_read,
    input  logic                         s1_write,
    input  logic [31:0]                  s1_writeData,
    input  logic                         s1_beginBurstTransfer,
    input  logic [BURST_COUNT_WIDTH-1:0] s1_burstCount,
    output logic                         s1_waitRequest,
    output logic [31:0]                  s1_readData,
    output logic                         s1_readDataValid,

    output logic [ADDR_WIDTH-1:0]        m0_address,
    output logic [3:0]                   m0_byteEnable,
    output logic                         m0_read,
    output logic                         m0_write,
    output logic [31:0]                  m0_writeData,
    output logic                         m0_beginBurstTransfer,
    output logic [BURST_COUNT_WIDTH-1:0] m0_burstCount,
    input  logic                         m0_waitRequest,
    input  logic [31:0]                  m0_readData,
    input  logic                         m0_readDataValid,

    output logic                         bus_idle
);

    localparam logic [BURST_COUNT_WIDTH-1:0] BC_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } state_t;

    state_t                       state;
    logic                         g;      // current grant: 0 = s0, 1 = s1
    logic [BURST_COUNT_WIDTH-1:0] cnt;    // beats remaining in the burst
`ifndef CACHE_BUS_ARB_FIXED_PRIO_EN
    logic                         last_grant;
`endif

    // -------------------------------------------------------------------------
    // Granted-master view. Everything downstream works on sel_* so that the
    // FSM and the output logic are written once for both masters.
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]        sel_address;
    logic [3:0]                   sel_byteEnable;
    logic                         sel_read;
    logic                         sel_write;
    logic [31:0]                  sel_writeData;
    logic                         sel_beginBurstTransfer;
    logic [BURST_COUNT_WIDTH-1:0] sel_burstCount;

    always_comb begin
        if (g) begin
            sel_address            = s1_address;
            sel_byteEnable         = s1_byteEnable;
            sel_read               = s1_read;
            sel_write              = s1_write;
            sel_writeData          = s1_writeData;
            sel_beginBurstTransfer = s1_beginBurstTransfer;
            sel_burstCount         = s1_burstCount;
        end else begin
            sel_address            = s0_address;
            sel_byteEnable         = s0_byteEnable;
            sel_read               = s0_read;
            sel_write              = s0_write;
            sel_writeData          = s0_writeData;
            sel_beginBurstTransfer = s0_beginBurstTransfer;
            sel_burstCount         = s0_burstCount;
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic req0, req1, win;

    assign req0 = s0_read | s0_write;
    assign req1 = s1_read | s1_write;

    always_comb begin
        win = req1;
        if (req0 && req1) begin
`ifdef CACHE_BUS_ARB_FIXED_PRIO_EN
            win = 1'b1;
`else
            win = ~last_grant;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Burst bookkeeping
    // -------------------------------------------------------------------------
    logic [BURST_COUNT_WIDTH-1:0] bc_eff;
    logic                         cmd_acc;
    logic                         wr_beat;
    logic                         burst_done;

    // A burstCount of zero is treated as a single beat.
    assign bc_eff  = (sel_burstCount == '0) ? BC_ONE : sel_burstCount;

    assign cmd_acc = (sel_read | sel_write) & ~m0_waitRequest;
    assign wr_beat = sel_write & ~m0_waitRequest;

    // Final beat of a burst. A read command gives an accept-only beat, because
    // its data arrives later in RDATA. cnt <= 1 also guards against an
    // unreachable zero count.
    always_comb begin
        burst_done = 1'b0;
        case (state)
            CMD:     burst_done = ~sel_read & wr_beat & (bc_eff == BC_ONE);
            RDATA:   burst_done = m0_readDataValid & (cnt <= BC_ONE);
            WDATA:   burst_done = wr_beat & (cnt <= BC_ONE);
            default: burst_done = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state      <= IDLE;
            g          <= 1'b0;
            cnt        <= '0;
`ifndef CACHE_BUS_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
`ifndef CACHE_BUS_ARB_FIXED_PRIO_EN
            if (burst_done)
                last_grant <= g;
`endif
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        g     <= win;
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (!sel_read && !sel_write) begin
                        // Master withdrew before acceptance; the grant is
                        // dropped without counting as a turn.
                        state <= IDLE;
                    end else if (cmd_acc) begin
                        if (sel_read) begin
                            cnt   <= bc_eff;
                            state <= RDATA;
                        end else if (bc_eff == BC_ONE) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= bc_eff - BC_ONE;
                            state <= WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (m0_readDataValid) begin
                        cnt <= cnt - BC_ONE;
                        if (burst_done)
                            state <= IDLE;
                    end
                end
                WDATA: begin
                    if (wr_beat) begin
                        cnt <= cnt - BC_ONE;
                        if (burst_done)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bus-side outputs
    // -------------------------------------------------------------------------
    always_comb begin
        m0_address            = '0;
        m0_byteEnable         = '0;
        m0_read               = 1'b0;
        m0_write              = 1'b0;
        m0_writeData          = '0;
        m0_beginBurstTransfer = 1'b0;
        m0_burstCount         = '0;
        case (state)
            CMD: begin
                m0_address            = sel_address;
                m0_byteEnable         = sel_byteEnable;
                m0_read               = sel_read;
                m0_write              = sel_write;
                m0_writeData          = sel_writeData;
                m0_beginBurstTransfer = sel_beginBurstTransfer;
                m0_burstCount         = sel_burstCount;
            end
            WDATA: begin
                // Write data beats carry no command, so no read and no
                // burst-start marker.
                m0_address    = sel_address;
                m0_byteEnable = sel_byteEnable;
                m0_write      = sel_write;
                m0_writeData  = sel_writeData;
                m0_burstCount = sel_burstCount;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Master-side outputs
    // -------------------------------------------------------------------------
    logic pass_wait;    // the granted master sees the bus stall directly
    logic pass_valid;   // read beats go to the granted master only

    assign pass_wait  = (state == CMD) || (state == WDATA);
    assign pass_valid = (state == RDATA) & m0_readDataValid;

    assign s0_waitRequest   = (pass_wait && !g) ? m0_waitRequest : 1'b1;
    assign s1_waitRequest   = (pass_wait &&  g) ? m0_waitRequest : 1'b1;
    assign s0_readDataValid = pass_valid & ~g;
    assign s1_readDataValid = pass_valid &  g;

    // Read data is broadcast; readDataValid qualifies it per master.
    assign s0_readData = m0_readData;
    assign s1_readData = m0_readData;

    assign bus_idle = (state == IDLE) & ~req0 & ~req1;

endmodule

// File: tb/tb_cache_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_cache_bus_arb
//
// Directed testbench for cache_bus_arb.
//
// Inputs are driven on the falling edge of clk. Outputs are checked 1 time
// unit later, while the DUT is still holding the state registered at the
// previous rising edge. The expected winner of a simultaneous request follows
// the policy selected by CACHE_BUS_ARB_FIXED_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_cache_bus_arb;

    logic        clk = 1'b0;
    logic        rest = 1'b0;

    logic        rd    [2];
    logic        wr    [2];
    logic        bb    [2];
    logic [31:0] addr  [2];
    logic [7:0]  bc    [2];
    logic [31:0] wd    [2];
    logic [3:0]  be    [2];

    wire  [1:0]  wq;
    wire  [1:0]  rv;
    wire  [31:0] rdata0, rdata1;

    wire  [31:0] m_addr, m_wdata;
    wire  [3:0]  m_be;
    wire         m_read, m_write, m_bb;
    wire  [7:0]  m_bc;
    wire         bus_idle;

    logic        mwait = 1'b1;
    logic        mrdv  = 1'b0;
    logic [31:0] mdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_bus_arb #(.BURST_COUNT_WIDTH(8), .ADDR_WIDTH(32)) dut (
        .clk                   (clk),
        .rest                  (rest),
        .s0_address            (addr[0]),
        .s0_byteEnable         (be[0]),
        .s0_read               (rd[0]),
        .s0_write              (wr[0]),
        .s0_writeData          (wd[0]),
        .s0_beginBurstTransfer (bb[0]),
        .s0_burstCount         (bc[0]),
        .s0_waitRequest        (wq[0]),
        .s0_readData           (rdata0),
        .s0_readDataValid      (rv[0]),
        .s1_address            (addr[1]),
        .s1_byteEnable         (be[1]),
        .s1_read               (rd[1]),
        .s1_write              (wr[1]),
        .s1_writeData          (wd[1]),
        .s1_beginBurstTransfer (bb[1]),
        .s1_burstCount         (bc[1]),
        .s1_waitRequest        (wq[1]),
        .s1_readData           (rdata1),
        .s1_readDataValid      (rv[1]),
        .m0_address            (m_addr),
        .m0_byteEnable         (m_be),
        .m0_read               (m_read),
        .m0_write              (m_write),
        .m0_writeData          (m_wdata),
        .m0_beginBurstTransfer (m_bb),
        .m0_burstCount         (m_bc),
        .m0_waitRequest        (mwait),
        .m0_readData           (mdata),
        .m0_readDataValid      (mrdv),
        .bus_idle              (bus_idle)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one full cycle: from one falling edge to the next.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One IDLE cycle: the bus is quiet and both masters are stalled.
    task automatic idle_cyc(input logic exp_bi);
        mrdv  = 1'b0;
        mwait = 1'b1;
        #1;
        chk("idle_wq0", wq[0], 1);
        chk("idle_wq1", wq[1], 1);
        chk("idle_mrd", m_read, 0);
        chk("idle_mwr", m_write, 0);
        chk("idle_bi",  bus_idle, exp_bi);
        tick();
    endtask

    // Master w is in CMD with a read. The bus stalls for 'stalls' cycles,
    // accepts the command, and then returns n beats with a gap before beat 2.
    task automatic serve_rd(input int w, input int n, input int stalls);
        int o;
        o = 1 - w;
        for (int s = 0; s <= stalls; s++) begin
            mwait = (s < stalls);
            #1;
            chk("cmd_mrd",  m_read, 1);
            chk("cmd_addr", m_addr, addr[w]);
            chk("cmd_bc",   m_bc, bc[w]);
            chk("cmd_wq",   wq[w], mwait);
            chk("cmd_owq",  wq[o], 1);
            tick();
        end
        rd[w] = 1'b0;
        mwait = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == 2) begin
                mrdv = 1'b0;
                #1;
                chk("gap_rv", rv[w], 0);
                tick();
            end
            mrdv  = 1'b1;
            mdata = 32'hD000_0000 + w * 256 + i;
            #1;
            chk("rd_rv",   rv[w], 1);
            chk("rd_data", (w == 0) ? rdata0 : rdata1, mdata);
            chk("rd_orv",  rv[o], 0);
            chk("rd_mrd",  m_read, 0);
            chk("rd_wq",   wq[w], 1);
            tick();
        end
        mrdv = 1'b0;
    endtask

    initial begin
        int first;
        int beat;

        for (int i = 0; i < 2; i++) begin
            rd[i]   = 0;
            wr[i]   = 0;
            bb[i]   = 0;
            addr[i] = 0;
            bc[i]   = 0;
            wd[i]   = 0;
            be[i]   = 4'hF;
        end

        // ---- reset values
        @(negedge clk);
        #1;
        chk("rst_mrd", m_read, 0);
        chk("rst_mwr", m_write, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wq0", wq[0], 1);
        chk("rst_wq1", wq[1], 1);
        chk("rst_rv", rv, 0);
        chk("rst_bi", bus_idle, 1);
        tick();
        rest = 1'b1;
        tick();

        // ---- single s0 read: 8 beats at 0x100, bus stalls 2 cycles
        rd[0] = 1;
        addr[0] = 32'h100;
        bc[0] = 8;
        bb[0] = 1;
        idle_cyc(0);
        serve_rd(0, 8, 2);
        bb[0] = 0;
        // A stray readDataValid while IDLE must be dropped.
        mrdv = 1'b1;
        #1;
        chk("stray_rv", rv, 0);
        chk("end_bi", bus_idle, 1);
        tick();
        mrdv = 1'b0;

        // ---- simultaneous requests right after reset
        rest = 1'b0;
        #1;
        rest = 1'b1;
`ifdef CACHE_BUS_ARB_FIXED_PRIO_EN
        first = 1;
`else
        first = 0;
`endif
        rd[0] = 1;
        rd[1] = 1;
        addr[0] = 32'h200;
        addr[1] = 32'h300;
        bc[0] = 2;
        bc[1] = 2;
        idle_cyc(0);
        serve_rd(first, 2, 0);
        idle_cyc(0);               // mandatory gap before the other master
        serve_rd(1 - first, 2, 0);

        // ---- s0 alone, then both: s1 must win in either policy
        rd[0] = 1;
        idle_cyc(0);
        serve_rd(0, 2, 0);
        rd[0] = 1;
        rd[1] = 1;
        idle_cyc(0);
        serve_rd(1, 2, 0);
        idle_cyc(0);
        serve_rd(0, 2, 0);

        // ---- s1 write of 4 beats with the bus toggling; s0 waits with a read
        wr[1] = 1;
        bb[1] = 1;
        addr[1] = 32'h400;
        bc[1] = 4;
        rd[0] = 1;
        idle_cyc(0);
        beat = 0;
        for (int k = 0; k < 20 && beat < 4; k++) begin
            mwait = (k % 2 == 0);
            wd[1] = 32'hA0 + beat;
            #1;
            chk("wr_mwr",  m_write, 1);
            chk("wr_mrd",  m_read, 0);
            chk("wr_data", m_wdata, 32'hA0 + beat);
            chk("wr_addr", m_addr, 32'h400);
            chk("wr_bb",   m_bb, (beat == 0));
            chk("wr_wq1",  wq[1], mwait);
            chk("wr_wq0",  wq[0], 1);
            if (!mwait)
                beat++;
            tick();
        end
        chk("wr_beats", beat, 4);
        wr[1] = 0;
        bb[1] = 0;
        idle_cyc(0);               // back in IDLE with s0 still requesting
        serve_rd(0, 2, 0);

        // ---- single-beat writes with burstCount 0 and 1
        for (int b = 0; b < 2; b++) begin
            wr[0] = 1;
            bc[0] = b[7:0];
            addr[0] = 32'h500 + b;
            wd[0] = 32'h55;
            idle_cyc(0);
            mwait = 1'b0;
            #1;
            chk("sw_mwr", m_write, 1);
            chk("sw_bc",  m_bc, b);
            chk("sw_wq",  wq[0], 0);
            tick();
            wr[0] = 0;
            mwait = 1'b1;
            #1;
            chk("sw_bi",  bus_idle, 1);
            chk("sw_mwr2", m_write, 0);
            tick();
        end

        // ---- reset during beat 3 of an 8-beat read
        rd[0] = 1;
        addr[0] = 32'h600;
        bc[0] = 8;
        idle_cyc(0);
        mwait = 1'b0;
        tick();                    // command accepted
        rd[0] = 0;
        mwait = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mrdv = 1'b1;
            tick();
        end
        mrdv = 1'b1;
        rest = 1'b0;
        #1;
        chk("mr_rv",  rv, 0);
        chk("mr_wq0", wq[0], 1);
        chk("mr_wq1", wq[1], 1);
        chk("mr_mrd", m_read, 0);
        chk("mr_bi",  bus_idle, 1);
        tick();
        rest = 1'b1;
        mrdv = 1'b0;
        rd[1] = 1;
        addr[1] = 32'h700;
        bc[1] = 2;
        idle_cyc(0);
        serve_rd(1, 2, 0);
        #1;
        chk("fin_bi", bus_idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
